// File: rtl/addsub_pkg.sv
// Shared types and helpers for the digit-serial adder/subtractor.
// Latency: none (declarations only).
// Backpressure: not applicable.
package addsub_pkg;

  // Controller states: accept command, process slices, hold result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of the slice counter; never narrower than one bit so NDIG=1 still has a counter.
  function automatic int cnt_width(input int ndig);
    return (ndig > 1) ? $clog2(ndig) : 1;
  endfunction

endpackage

// File: rtl/add_digit.sv
// Combinational DIGIT-bit adder slice with carry-in, carry-out and carry into its MSB.
// Latency: combinational, zero cycles.
// Backpressure: none; purely combinational.
module add_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [DIGIT:0] full;

  // One wide add; the carry into the top bit is recovered from sum ^ a ^ b at that bit,
  // which for DIGIT=1 collapses to cin itself.
  always_comb begin
    full  = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, cin};
    sum   = full[DIGIT-1:0];
    cout  = full[DIGIT];
    c_msb = full[DIGIT-1] ^ a[DIGIT-1] ^ b[DIGIT-1];
  end

endmodule

// File: rtl/addsub_seq.sv
// Digit-serial WIDTH-bit add/subtract, DIGIT bits per clock, LSB slice first; flags cout/ovf/zero.
// Latency: result valid WIDTH/DIGIT cycles after the accepting edge; accepts spaced WIDTH/DIGIT+2 cycles.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
module addsub_seq
  import addsub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = cnt_width(NDIG);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [DIGIT-1:0] d_sum;
  logic             d_cout;
  logic             d_cmsb;
  logic             last;
  logic             accept;

  add_digit #(.DIGIT(DIGIT)) u_digit (
    .a     (op_a[DIGIT-1:0]),
    .b     (op_b[DIGIT-1:0]),
    .cin   (carry),
    .sum   (d_sum),
    .cout  (d_cout),
    .c_msb (d_cmsb)
  );

  assign last   = (cnt == CW'(NDIG - 1));
  assign accept = in_valid && in_ready;
  // New slice enters at the top; after NDIG slices the LSB slice has reached bit 0.
  assign acc_nxt = (acc >> DIGIT) | (WIDTH'(d_sum) << (WIDTH - DIGIT));

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic for the accept / run / hold sequence.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Registered handshake outputs, decoded from the next state so they track it exactly;
  // in_ready therefore rises on the first edge after reset release.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      in_ready  <= (state_nxt == IDLE);
      out_valid <= (state_nxt == DONE);
    end
  end

  // Operand capture, slice-by-slice accumulation and final flag latch.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      op_a  <= '0;
      op_b  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      s     <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_a  <= a;
            // Subtraction as a + ~b + 1 - cin: invert b, and the inverted borrow seeds the carry.
            op_b  <= sub ? ~b : b;
            carry <= cin ^ sub;
            cnt   <= '0;
          end
        end
        RUN: begin
          carry <= d_cout;
          op_a  <= op_a >> DIGIT;
          op_b  <= op_b >> DIGIT;
          acc   <= acc_nxt;
          if (last) begin
            // Visible result updates only here, so s and flags stay put in IDLE and RUN.
            s    <= acc_nxt;
            cout <= d_cout;
            ovf  <= d_cmsb ^ d_cout;
            zero <= (acc_nxt == '0);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_seq.sv
// Bench for addsub_seq: directed 8-bit vectors and handshake/reset sequences, plus
// random sweeps of 32-bit instances with DIGIT = 1, 4 and 32 against an arithmetic model.
// Timing: inputs driven and outputs sampled 1 time unit after the rising clock edge.
module tb_addsub_seq;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  bit start32  = 1'b0;
  logic rst32  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic mark_done();
    done_cnt++;
  endtask

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic void ref_op(input int w, input longint ua, input longint ub,
                                 input bit ci, input bit sb,
                                 output longint rs, output bit rc, output bit rov, output bit rz);
    longint m, half, sa, sbv, u, r;
    m    = longint'(1) << w;
    half = m >> 1;
    sa   = (ua >= half) ? ua - m : ua;
    sbv  = (ub >= half) ? ub - m : ub;
    if (sb) begin
      u  = ua - ub - longint'(ci);
      rc = (u >= 0);
      r  = sa - sbv - longint'(ci);
    end else begin
      u  = ua + ub + longint'(ci);
      rc = (u >= m);
      r  = sa + sbv + longint'(ci);
    end
    rs  = u & (m - 1);
    rov = (r < -half) || (r >= half);
    rz  = (rs == 0);
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- 8-bit, DIGIT=4 instance ----------------
  logic       rst8, iv8, rdy8, ov8, or8, ci8, sb8, co8, of8, z8;
  logic [7:0] a8, b8, s8;

  addsub_seq #(.WIDTH(8), .DIGIT(4)) dut (
    .clock(clock), .reset(rst8), .in_valid(iv8), .in_ready(rdy8),
    .a(a8), .b(b8), .cin(ci8), .sub(sb8),
    .out_valid(ov8), .out_ready(or8),
    .s(s8), .cout(co8), .ovf(of8), .zero(z8)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] s;
    logic       cout;
    logic       ovf;
    logic       zero;
  } vec_t;

  vec_t vt[9];

  task automatic wait_ready8();
    int n = 0;
    while (!rdy8 && n < 20) begin
      @(posedge clock); #1; n++;
    end
    check("in_ready wait", 64'(rdy8), 64'(1));
  endtask

  task automatic run8(input logic [7:0] ia, input logic [7:0] ib,
                      input logic ic, input logic is, output int lat);
    wait_ready8();
    a8 = ia; b8 = ib; ci8 = ic; sb8 = is; iv8 = 1'b1;
    @(posedge clock); #1;
    iv8 = 1'b0;
    lat = 0;
    while (!ov8 && lat < 40) begin
      @(posedge clock); #1; lat++;
    end
  endtask

  task automatic release8();
    or8 = 1'b1;
    @(posedge clock); #1;
    or8 = 1'b0;
  endtask

  // ---------------- 32-bit sweep instances ----------------
  for (genvar g = 0; g < 3; g++) begin : g_sweep
    localparam int DG = (g == 0) ? 1 : ((g == 1) ? 4 : 32);
    localparam int ND = 32 / DG;
    logic        iv, ir, ov, ordy, ci, sb, co, of, z;
    logic [31:0] ra, rb, rs;

    addsub_seq #(.WIDTH(32), .DIGIT(DG)) u_dut (
      .clock(clock), .reset(rst32), .in_valid(iv), .in_ready(ir),
      .a(ra), .b(rb), .cin(ci), .sub(sb),
      .out_valid(ov), .out_ready(ordy),
      .s(rs), .cout(co), .ovf(of), .zero(z)
    );

    initial begin
      int     lat, n;
      longint es;
      bit     ec, eo, ez;
      string  tag;
      tag = $sformatf("d%0d", DG);
      iv = 1'b0; ordy = 1'b0; ra = '0; rb = '0; ci = 1'b0; sb = 1'b0;
      while (!start32) @(posedge clock);
      #1;
      for (int i = 0; i < 1000; i++) begin
        ra = pick(); rb = pick();
        ci = 1'($urandom_range(0, 1));
        sb = 1'($urandom_range(0, 1));
        n = 0;
        while (!ir && n < 20) begin
          @(posedge clock); #1; n++;
        end
        iv = 1'b1;
        @(posedge clock); #1;
        iv = 1'b0;
        lat = 0;
        while (!ov && lat < ND + 10) begin
          @(posedge clock); #1; lat++;
        end
        ref_op(32, longint'(ra), longint'(rb), ci, sb, es, ec, eo, ez);
        check({tag, " latency"}, 64'(lat), 64'(ND));
        check({tag, " s"},       64'(rs),  64'(es[31:0]));
        check({tag, " cout"},    64'(co),  64'(ec));
        check({tag, " ovf"},     64'(of),  64'(eo));
        check({tag, " zero"},    64'(z),   64'(ez));
        repeat ($urandom_range(0, 2)) begin
          @(posedge clock); #1;
        end
        ordy = 1'b1;
        @(posedge clock); #1;
        ordy = 1'b0;
      end
      mark_done();
    end
  end

  // ---------------- directed sequences ----------------
  initial begin
    int lat;
    int acc_q[$];
    bit acc;
    int n;

    vt[0] = '{8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0, 1'b0};
    vt[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
    vt[2] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
    vt[3] = '{8'h10, 8'h01, 1'b1, 1'b1, 8'h0E, 1'b1, 1'b0, 1'b0};
    vt[4] = '{8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0};
    vt[5] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
    vt[6] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0};
    vt[7] = '{8'h55, 8'hAA, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
    vt[8] = '{8'h05, 8'h05, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};

    rst8 = 1'b0; iv8 = 1'b0; or8 = 1'b0; a8 = '0; b8 = '0; ci8 = 1'b0; sb8 = 1'b0;
    #3;
    check("reset s",         64'(s8),   64'(0));
    check("reset out_valid", 64'(ov8),  64'(0));
    check("reset in_ready",  64'(rdy8), 64'(0));
    check("reset flags",     64'({co8, of8, z8}), 64'(0));
    #19;
    rst8 = 1'b1; rst32 = 1'b1;
    @(posedge clock); #1;
    check("in_ready after reset", 64'(rdy8), 64'(1));
    start32 = 1'b1;

    // Table of single transactions.
    for (int i = 0; i < 9; i++) begin
      run8(vt[i].a, vt[i].b, vt[i].cin, vt[i].sub, lat);
      check($sformatf("vec%0d latency", i), 64'(lat), 64'(2));
      check($sformatf("vec%0d s", i),       64'(s8),  64'(vt[i].s));
      check($sformatf("vec%0d cout", i),    64'(co8), 64'(vt[i].cout));
      check($sformatf("vec%0d ovf", i),     64'(of8), 64'(vt[i].ovf));
      check($sformatf("vec%0d zero", i),    64'(z8),  64'(vt[i].zero));
      release8();
    end

    // Second command held during RUN is ignored; result held under backpressure.
    wait_ready8();
    a8 = 8'h21; b8 = 8'h10; ci8 = 1'b0; sb8 = 1'b0; iv8 = 1'b1;
    @(posedge clock); #1;
    a8 = 8'h99; b8 = 8'h99; ci8 = 1'b1;
    n = 0;
    while (!ov8 && n < 40) begin
      @(posedge clock); #1; n++;
    end
    iv8 = 1'b0;
    check("ignore 2nd cmd s", 64'(s8), 64'(8'h31));
    for (int c = 0; c < 5; c++) begin
      check($sformatf("hold%0d s", c),         64'(s8),   64'(8'h31));
      check($sformatf("hold%0d out_valid", c), 64'(ov8),  64'(1));
      check($sformatf("hold%0d in_ready", c),  64'(rdy8), 64'(0));
      @(posedge clock); #1;
    end
    release8();
    check("after release out_valid", 64'(ov8),  64'(0));
    check("after release in_ready",  64'(rdy8), 64'(1));

    // Back-to-back: continuous in_valid and out_ready.
    a8 = 8'h01; b8 = 8'h02; ci8 = 1'b0; sb8 = 1'b0; iv8 = 1'b1; or8 = 1'b1;
    for (int c = 0; c < 16; c++) begin
      acc = iv8 && rdy8;
      @(posedge clock); #1;
      if (acc) acc_q.push_back(c);
    end
    iv8 = 1'b0;
    check("b2b accept count>=3", 64'(acc_q.size() >= 3), 64'(1));
    for (int i = 1; i < acc_q.size(); i++)
      check($sformatf("b2b spacing %0d", i), 64'(acc_q[i] - acc_q[i-1]), 64'(4));
    n = 0;
    while (!(rdy8 && !ov8) && n < 20) begin
      @(posedge clock); #1; n++;
    end
    or8 = 1'b0;

    // Leave nonzero outputs behind, then reset during the second RUN cycle.
    run8(8'hF0, 8'h20, 1'b0, 1'b0, lat);
    check("pre-reset s",    64'(s8),  64'(8'h10));
    check("pre-reset cout", 64'(co8), 64'(1));
    release8();
    wait_ready8();
    a8 = 8'h55; b8 = 8'h11; iv8 = 1'b1;
    @(posedge clock); #1;
    iv8 = 1'b0;
    @(posedge clock); #2;
    rst8 = 1'b0;
    #1;
    check("midrun reset s",         64'(s8),   64'(0));
    check("midrun reset cout",      64'(co8),  64'(0));
    check("midrun reset ovf/zero",  64'({of8, z8}), 64'(0));
    check("midrun reset out_valid", 64'(ov8),  64'(0));
    check("midrun reset in_ready",  64'(rdy8), 64'(0));
    #4;
    rst8 = 1'b1;
    @(posedge clock); #1;
    check("post-reset in_ready",  64'(rdy8), 64'(1));
    check("post-reset out_valid", 64'(ov8),  64'(0));
    run8(8'h03, 8'h04, 1'b0, 1'b0, lat);
    check("post-reset latency", 64'(lat), 64'(2));
    check("post-reset s",       64'(s8),  64'(8'h07));
    release8();

    // Wait for the random sweeps.
    n = 0;
    while (done_cnt < 3 && n < 60000) begin
      @(posedge clock); n++;
    end
    check("sweeps completed", 64'(done_cnt), 64'(3));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/addsub_seq.md
Name: addsub_seq

Overview:
Parametrised multi-cycle adder/subtractor and the successor of the team's fixed 4-bit carry-in/carry-out adder.
- Processes a WIDTH-bit operation in DIGIT-bit slices, LSB slice first, one slice per clock.
- Carries between slices through a carry register.
- Used by the datapath where area matters more than latency, e.g. multiply/divide helper paths.
- Valid/ready handshake on input and output. Reports carry, signed overflow and zero flags.

Parameters:
WIDTH, 32, operand/result width in bits; must be a multiple of DIGIT.
DIGIT, 4, bits processed per cycle; 1 <= DIGIT <= WIDTH.
NDIG (localparam), WIDTH/DIGIT, number of RUN cycles.

Ports:
clock  input  1  single clock, rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset).
in_valid  input  1  operands/command valid.
in_ready  output  1  block can accept a command.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
cin  input  1  carry-in (add) / borrow-in (sub).
sub  input  1  0: s = a + b + cin; 1: s = a - b - cin.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts result.
s  output  WIDTH  result, modulo 2^WIDTH.
cout  output  1  raw carry out of MSB; for sub, cout=1 means no borrow.
ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.
zero  output  1  s == 0.

Behaviour:
- Reset (reset=0, asynchronous, any state including mid-RUN):
  - state=IDLE; pending operation is discarded.
  - s=0, cout=0, ovf=0, zero=0, out_valid=0, slice counter=0.
  - in_ready=1 once reset deasserts.
- States:
  - IDLE: in_ready=1, out_valid=0. On in_valid=1 at a clock edge, capture:
    - opA <= a; opB <= sub ? ~b : b; carry <= cin XOR sub; counter <= 0.
    - Go to RUN.
  - RUN: in_ready=0, out_valid=0. Each cycle:
    - {c, slice} = opA[DIGIT-1:0] + opB[DIGIT-1:0] + carry.
    - carry <= c; opA and opB shift right by DIGIT; slice is shifted into the result register from the MSB side.
    - On the last slice (counter == NDIG-1): latch cout=c and ovf = (carry into MSB) XOR c; compute zero from the final result; go to DONE.
    - Otherwise counter++.
  - DONE: out_valid=1; s/cout/ovf/zero are stable while held. If out_ready=1, go to IDLE (out_valid=0 the next cycle).
- Outputs:
  - All outputs are registered; s/cout/ovf/zero keep their last values in IDLE and RUN.
  - s is guaranteed only while out_valid=1.
- Latency: accept edge T → out_valid high after edge T+NDIG.
  - Minimum spacing between accepts is NDIG+2 cycles (one DONE cycle, one IDLE bubble).
- Input changes while in_ready=0 are ignored. in_valid is sampled only in IDLE.
- DIGIT == WIDTH (NDIG=1) is legal: a single RUN cycle.
- Wrap-around: result is modulo 2^WIDTH; cout and ovf report the wrap; no saturation.
- ovf needs the carry into the MSB:
  - For DIGIT=1, it is the carry register before the last slice.
  - Otherwise it is derived inside the final slice from the add of the top bit.

Decomposition:
- Shared package (addsub_pkg) holds:
  - state enum {IDLE, RUN, DONE};
  - localparam helper for the counter width, $clog2(NDIG) (minimum 1).
- One natural sub-module: add_digit #(DIGIT).
  - Combinational DIGIT-bit adder with cin.
  - Outputs sum, cout, and the carry into its MSB (c_msb), used for ovf.
- The FSM, shift registers and flags live in addsub_seq.

Test Plan (WIDTH=8, DIGIT=4 unless noted):
- Add, no carry: a=0x12, b=0x34, cin=0, sub=0 → after 2 RUN cycles out_valid=1; s=0x46, cout=0, ovf=0, zero=0; out_valid held until out_ready=1.
- Add, carry and zero: a=0xFF, b=0x01, cin=0 → s=0x00, cout=1, ovf=0, zero=1. Then a=0x7F, b=0x01 → s=0x80, ovf=1, cout=0.
- Subtract with borrow: a=0x10, b=0x01, cin=1, sub=1 → s=0x0E, cout=1 (no borrow). Then a=0x00, b=0x01, cin=0, sub=1 → s=0xFF, cout=0, ovf=0.
- Handshake/backpressure:
  - Hold out_ready=0 for 5 cycles → s stable; in_ready=0 throughout.
  - A second in_valid during RUN is ignored.
  - Back-to-back transactions are accepted exactly NDIG+2 cycles apart.
- Reset mid-operation: assert reset=0 asynchronously, off-edge, during the 2nd RUN cycle → all outputs 0 immediately, in_ready=1 after release. The next command (0x03+0x04) gives s=0x07.
- Parameter sweep:
  - WIDTH=32 with DIGIT=1, 4 and 32 (NDIG=32/8/1); 1000 random ops per configuration.
  - Check each against a reference model for {cout,s}, ovf and zero.
  - Check latency equals NDIG.
